// File: rtl/dual_port_ram_be_if.sv
// Bus bundle for dual_port_ram_be.
// Carries both access ports plus the shared collision flag.
interface dual_port_ram_be_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  en_a;
  logic                  we_a;
  logic [NB-1:0]         be_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] q_a;
  logic                  q_valid_a;

  logic                  en_b;
  logic                  we_b;
  logic [NB-1:0]         be_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  q_valid_b;

  logic                  collision;

  modport master (
    output en_a, we_a, be_a,
    output addr_a, data_a,
    input  q_a, q_valid_a,
    output en_b, we_b, be_b,
    output addr_b, data_b,
    input  q_b, q_valid_b,
    input  collision
  );

  modport slave (
    input  en_a, we_a, be_a,
    input  addr_a, data_a,
    output q_a, q_valid_a,
    input  en_b, we_b, be_b,
    input  addr_b, data_b,
    output q_b, q_valid_b,
    output collision
  );
endinterface

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte-lane writes, read-during-write modes,
// optional output register, read-valid flags and collision detection.
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic               clk,
  input logic               rst,
  dual_port_ram_be_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic word_t lane_mask(
    input logic [NB-1:0] be
  );
    word_t m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  word_t mem [DEPTH];

  logic [1:0]                  en;
  logic [1:0]                  we;
  logic [1:0]                  wr;
  logic [1:0][NB-1:0]          be;
  logic [1:0][ADDR_WIDTH-1:0]  addr;
  logic [1:0][DATA_WIDTH-1:0]  din;
  logic [1:0][DATA_WIDTH-1:0]  old;
  logic [1:0][DATA_WIDTH-1:0]  upd;
  logic [1:0][DATA_WIDTH-1:0]  mask;
  logic [1:0][DATA_WIDTH-1:0]  d1;
  logic [1:0]                  v1_n;
  logic                        same;
  logic                        coll_n;

  logic [1:0][DATA_WIDTH-1:0]  q1;
  logic [1:0]                  v1;
  logic [1:0][DATA_WIDTH-1:0]  qo;
  logic [1:0]                  vo;
  logic                        coll_q;

  assign en   = {bus.en_b, bus.en_a};
  assign we   = {bus.we_b, bus.we_a};
  assign be   = {bus.be_b, bus.be_a};
  assign addr = {bus.addr_b, bus.addr_a};
  assign din  = {bus.data_b, bus.data_a};

  // Port A owns any lane both ports write at the same address.
  always_comb begin
    same    = addr[0] == addr[1];
    wr      = en & we & {2{~rst}};
    mask[0] = wr[0] ? lane_mask(be[0]) : '0;
    mask[1] = wr[1] ? lane_mask(be[1]) : '0;
    if (same) begin
      mask[1] = mask[1] & ~mask[0];
    end
    for (int p = 0; p < 2; p++) begin
      old[p] = mem[addr[p]];
      upd[p] = old[p];
      for (int w = 0; w < 2; w++) begin
        if (addr[w] == addr[p]) begin
          upd[p] = (upd[p] & ~mask[w])
                 | (din[w] & mask[w]);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      v1_n[p] = en[p]
              & (~we[p] | (RDW_MODE != 2));
      d1[p]   = (we[p] && RDW_MODE == 1)
              ? upd[p] : old[p];
    end
    coll_n = en[0] & en[1] & same
           & (we[0] | we[1]);
  end

  // upd already holds the fully merged word, so a same-address
  // double write stores one identical value from both ports.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr[p]) begin
        mem[addr[p]] <= upd[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1     <= '0;
      v1     <= '0;
      coll_q <= 1'b0;
    end else begin
      v1     <= v1_n;
      coll_q <= coll_n;
      for (int p = 0; p < 2; p++) begin
        if (v1_n[p]) begin
          q1[p] <= d1[p];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [1:0][DATA_WIDTH-1:0] q2;
      logic [1:0]                 v2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q2 <= '0;
          v2 <= '0;
        end else begin
          v2 <= v1;
          for (int p = 0; p < 2; p++) begin
            if (v1[p]) begin
              q2[p] <= q1[p];
            end
          end
        end
      end

      assign qo = q2;
      assign vo = v2;
    end else begin : g_noreg
      assign qo = q1;
      assign vo = v1;
    end
  endgenerate

  assign bus.q_a       = qo[0];
  assign bus.q_valid_a = vo[0];
  assign bus.q_b       = qo[1];
  assign bus.q_valid_b = vo[1];
  assign bus.collision = coll_q;
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench for dual_port_ram_be across all RDW/OUT_REG
// combinations, driven in lockstep from one reference memory.
module tb_dual_port_ram_be;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NG = 6;
  localparam int NQ = NG * 2;

  typedef struct packed {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          en_a = 0, we_a = 0;
  logic [1:0]    be_a = 0;
  logic [AW-1:0] addr_a = 0;
  logic [DW-1:0] data_a = 0;
  logic          en_b = 0, we_b = 0;
  logic [1:0]    be_b = 0;
  logic [AW-1:0] addr_b = 0;
  logic [DW-1:0] data_b = 0;

  logic [NG-1:0][1:0][DW-1:0] qw;
  logic [NG-1:0][1:0]         vw;
  logic [NG-1:0]              cw;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    dual_port_ram_be_if #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) bus ();

    dual_port_ram_be #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RDW_MODE(g % 3),
      .OUT_REG(g / 3)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    assign bus.en_a   = en_a;
    assign bus.we_a   = we_a;
    assign bus.be_a   = be_a;
    assign bus.addr_a = addr_a;
    assign bus.data_a = data_a;
    assign bus.en_b   = en_b;
    assign bus.we_b   = we_b;
    assign bus.be_b   = be_b;
    assign bus.addr_b = addr_b;
    assign bus.data_b = data_b;
    assign qw[g][0]   = bus.q_a;
    assign qw[g][1]   = bus.q_b;
    assign vw[g][0]   = bus.q_valid_a;
    assign vw[g][1]   = bus.q_valid_b;
    assign cw[g]      = bus.collision;
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mm [1<<AW];
  exp_t          expq [NQ][$];
  exp_t          collq [$];
  logic [DW-1:0] last [NQ];
  int            n_vec = 0;
  int            n_bad = 0;
  bit            chk_en = 0;
  bit            done = 0;
  bit            done_chk = 0;

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      if (chk_en) begin
        #1;
        for (int g = 0; g < NG; g++) begin
          for (int p = 0; p < 2; p++) begin
            check($sformatf("rst_q g%0d p%0d", g, p),
                  qw[g][p], '0);
            check($sformatf("rst_v g%0d p%0d", g, p),
                  DW'(vw[g][p]), '0);
          end
          check($sformatf("rst_coll g%0d", g),
                DW'(cw[g]), '0);
        end
      end
      for (int i = 0; i < NQ; i++) begin
        expq[i].delete();
        last[i] = '0;
      end
      collq.delete();
    end else if (chk_en) begin
      exp_t e;
      logic ec;
      for (int g = 0; g < NG; g++) begin
        for (int p = 0; p < 2; p++) begin
          logic ev;
          ev = 1'b0;
          if (expq[g*2+p].size() > 0 &&
              expq[g*2+p][0].cyc == cyc) begin
            e = expq[g*2+p].pop_front();
            last[g*2+p] = e.d;
            ev = 1'b1;
          end
          check($sformatf("valid g%0d p%0d c%0d", g, p, cyc),
                DW'(vw[g][p]), DW'(ev));
          check($sformatf("q g%0d p%0d c%0d", g, p, cyc),
                qw[g][p], last[g*2+p]);
        end
      end
      ec = 1'b0;
      if (collq.size() > 0 && collq[0].cyc == cyc) begin
        e  = collq.pop_front();
        ec = e.d[0];
      end
      for (int g = 0; g < NG; g++) begin
        check($sformatf("coll g%0d c%0d", g, cyc),
              DW'(cw[g]), DW'(ec));
      end
      if (done && !done_chk) begin
        done_chk = 1;
        for (int i = 0; i < NQ; i++) begin
          check($sformatf("drain q%0d", i),
                DW'(expq[i].size()), '0);
        end
      end
    end
  end

  task automatic push(input int idx, input int due,
                      input logic [DW-1:0] d);
    exp_t e;
    e.cyc = due;
    e.d   = d;
    expq[idx].push_back(e);
  endtask

  // One clock of stimulus; expectations come from the reference
  // memory: B's lanes land first, then A's lanes overwrite.
  task automatic drive(
    input logic ea, input logic wa, input logic [1:0] ba,
    input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic eb, input logic wb, input logic [1:0] bb,
    input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    exp_t c;
    en_a = ea; we_a = wa; be_a = ba;
    addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; be_b = bb;
    addr_b = ab; data_b = db;
    old_a = mm[aa];
    old_b = mm[ab];
    if (eb && wb)
      for (int i = 0; i < 2; i++)
        if (bb[i]) mm[ab][8*i +: 8] = db[8*i +: 8];
    if (ea && wa)
      for (int i = 0; i < 2; i++)
        if (ba[i]) mm[aa][8*i +: 8] = da[8*i +: 8];
    new_a = mm[aa];
    new_b = mm[ab];
    for (int g = 0; g < NG; g++) begin
      int mode, due;
      mode = g % 3;
      due  = cyc + 1 + g / 3;
      if (ea) begin
        if (!wa || mode == 0) push(g*2, due, old_a);
        else if (mode == 1)   push(g*2, due, new_a);
      end
      if (eb) begin
        if (!wb || mode == 0) push(g*2+1, due, old_b);
        else if (mode == 1)   push(g*2+1, due, new_b);
      end
    end
    c.cyc = cyc + 1;
    c.d   = DW'(ea && eb && aa == ab && (wa || wb));
    collq.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_a(input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input logic [1:0] b);
    drive(1, 1, b, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    drive(1, 0, 0, a, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    rst = 0;
    chk_en = 1;
    for (int a = 0; a < (1 << AW); a++)
      wr_a(AW'(a), DW'($urandom), 2'b11);
    // T1
    wr_a(5, 16'hBEEF, 2'b11);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    // T2
    wr_a(9, 16'h1234, 2'b11);
    wr_a(9, 16'hABCD, 2'b01);
    rd_a(9);
    // T3
    wr_a(3, 16'h0000, 2'b11);
    drive(1, 1, 2'b11, 3, 16'h1111, 1, 1, 2'b11, 3, 16'h2222);
    rd_a(3);
    drive(1, 1, 2'b01, 3, 16'h1111, 1, 1, 2'b10, 3, 16'h2222);
    rd_a(3);
    // T4
    wr_a(7, 16'h5555, 2'b11);
    drive(1, 1, 2'b11, 7, 16'hAAAA, 1, 0, 0, 7, 0);
    rd_a(7);
    // T5
    for (int a = 0; a < 4; a++) rd_a(AW'(a));
    idle();
    rd_a(4);
    rd_a(5);
    idle();
    idle();
    wr_a(12, 16'h0F0F, 2'b00);
    rd_a(12);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            1'($urandom), 2'($urandom),
            AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 3) != 0,
            1'($urandom), 2'($urandom),
            AW'($urandom_range(0, 7)), DW'($urandom));
    end
    // T6
    rd_a(10);
    drive(1, 0, 0, 11, 0, 1, 0, 0, 12, 0);
    #1;
    rst = 1;
    repeat (2) @(negedge clk);
    #2;
    rst = 0;
    for (int a = 0; a < (1 << AW); a++)
      drive(1, 0, 0, AW'(a), 0,
            1, 0, 0, AW'(63 - a), 0);
    repeat (3) idle();
    done = 1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
